// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the core's memory-stage SRAM-style port. Holds
// DEPTH 32-bit words, merges byte/half/word stores into the addressed lanes and
// returns loads right-justified and zero-extended READ_LAT cycles after the
// request is sampled. Misaligned, illegal-type and out-of-range accesses are
// rejected with an ERR pulse in the same response slot a read would occupy.
//
// Ports:
//   CLK     in   1   clock, all state updates on the rising edge
//   RST     in   1   asynchronous active-high reset
//   CSN     in   1   chip select, active low
//   WEN     in   1   0 = write, 1 = read (ignored when CSN = 1)
//   ADDR    in   AW  byte address
//   BE      in   5   one-hot access type: [0]=B [1]=BU [2]=H [3]=HU [4]=W
//   DI      in   32  store data, right-justified
//   DOUT    out  32  load data, right-justified, zero when DVALID = 0
//   DVALID  out  1   one-cycle pulse, DOUT holds a load response
//   ERR     out  1   one-cycle pulse, the access in this slot was rejected
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter int AW       = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CSN,
    input  logic          WEN,
    input  logic [AW-1:0] ADDR,
    input  logic [4:0]    BE,
    input  logic [31:0]   DI,
    output logic [31:0]   DOUT,
    output logic          DVALID,
    output logic          ERR
);

    localparam int          IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BYTE_LIMIT = DEPTH * 4;

    // Configuration guards: stop elaboration on an unsupported setup.
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("dmem_responder: READ_LAT must be in 1..4");
    end
    if (AW < IW + 2 || AW > 32) begin : g_bad_aw
        $error("dmem_responder: AW too small for DEPTH or wider than 32");
    end

    // One response slot; data is already formatted and zero when not a load.
    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] mem [DEPTH];

    logic          is_b;
    logic          is_h;
    logic          is_w;
    logic          legal;
    logic          wr_en;
    logic [IW-1:0] word_idx;
    logic [1:0]    lane;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_fmt;

    rsp_t rsp_d [READ_LAT];
    rsp_t rsp_q [READ_LAT];

    // Request decode, legality check and store-lane generation.
    // NOTE: every signal gets a default at the top of always_comb so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        is_b     = BE[0] | BE[1];
        is_h     = BE[2] | BE[3];
        is_w     = BE[4];
        lane     = ADDR[1:0];
        word_idx = ADDR[IW+1:2];
        legal    = $onehot(BE)
                   && !(is_h && ADDR[0])
                   && !(is_w && (lane != 2'b00))
                   && (32'(ADDR) < BYTE_LIMIT);
        wr_en    = !RST && !CSN && !WEN && legal;

        wmask = 4'b0000;
        wdata = DI;
        if (is_b) begin
            wmask = 4'b0001 << lane;
            wdata = {4{DI[7:0]}};
        end else if (is_h) begin
            wmask = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{DI[15:0]}};
        end else if (is_w) begin
            wmask = 4'b1111;
        end

        // Load formatting happens at the sample edge so the pipeline only
        // carries the final right-justified value.
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {lane, 3'b000};
        if (is_w) begin
            rd_fmt = rd_word;
        end else if (is_h) begin
            rd_fmt = {16'h0000, rd_shift[15:0]};
        end else begin
            rd_fmt = {24'h000000, rd_shift[7:0]};
        end
    end

    // Response pipeline: slot 0 is loaded from the request, later slots shift.
    always_comb begin
        rsp_d[0].vld  = !CSN && WEN && legal;
        rsp_d[0].err  = !CSN && !legal;
        rsp_d[0].data = (!CSN && WEN && legal) ? rd_fmt : 32'h0;
        for (int i = 1; i < READ_LAT; i++) begin
            rsp_d[i] = rsp_q[i-1];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < READ_LAT; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                rsp_q[i] <= rsp_d[i];
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive
    // RST and stay X until written, which keeps it mappable to SRAM.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wmask[i]) begin
                mem[word_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign DVALID = rsp_q[READ_LAT-1].vld;
    assign ERR    = rsp_q[READ_LAT-1].err;
    assign DOUT   = rsp_q[READ_LAT-1].data;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder (DEPTH=16, READ_LAT=3). Every cycle's
// request produces one expected response slot (idle, error or load data) that
// is compared against DVALID/ERR/DOUT READ_LAT cycles later. Expectations come
// either from a directed vector table or from a byte-addressed reference model.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH    = 16;
    localparam int READ_LAT = 3;
    localparam int AW       = 12;

    localparam logic [4:0] BE_B  = 5'b00001;
    localparam logic [4:0] BE_BU = 5'b00010;
    localparam logic [4:0] BE_H  = 5'b00100;
    localparam logic [4:0] BE_HU = 5'b01000;
    localparam logic [4:0] BE_W  = 5'b10000;

    typedef struct packed {
        logic          csn;
        logic          wen;
        logic [AW-1:0] addr;
        logic [4:0]    be;
        logic [31:0]   di;
    } req_t;

    typedef struct packed {
        logic        dv;
        logic        err;
        logic [31:0] dout;
    } rsp_t;

    typedef struct {
        string name;
        req_t  req;
        rsp_t  exp;
    } vec_t;

    typedef struct {
        string name;
        rsp_t  rsp;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CSN;
    logic          WEN;
    logic [AW-1:0] ADDR;
    logic [4:0]    BE;
    logic [31:0]   DI;
    logic [31:0]   DOUT;
    logic          DVALID;
    logic          ERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [DEPTH*4];
    exp_t       exp_q [$];
    vec_t       vecs [$];

    dmem_responder #(
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .AW       (AW)
    ) u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .CSN    (CSN),
        .WEN    (WEN),
        .ADDR   (ADDR),
        .BE     (BE),
        .DI     (DI),
        .DOUT   (DOUT),
        .DVALID (DVALID),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian storage, rules applied
    // directly to the request.
    task automatic model_apply(input req_t r, output rsp_t o);
        int  a;
        bit  legal;
        bit  h;
        o = '0;
        if (r.csn) return;
        a     = int'(r.addr);
        h     = r.be[2] | r.be[3];
        legal = $onehot(r.be) && !(h && a % 2 != 0)
                && !(r.be[4] && a % 4 != 0) && (a < DEPTH * 4);
        if (!legal) begin
            o.err = 1'b1;
            return;
        end
        if (!r.wen) begin
            if (r.be[0] | r.be[1]) begin
                ref_mem[a] = r.di[7:0];
            end else if (h) begin
                ref_mem[a]   = r.di[7:0];
                ref_mem[a+1] = r.di[15:8];
            end else begin
                for (int k = 0; k < 4; k++) ref_mem[a+k] = r.di[8*k +: 8];
            end
        end else begin
            o.dv = 1'b1;
            if (r.be[0] | r.be[1])
                o.dout = {24'h0, ref_mem[a]};
            else if (h)
                o.dout = {16'h0, ref_mem[a+1], ref_mem[a]};
            else
                o.dout = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        end
    endtask

    // One clock: drive request, update model at the edge, queue this slot's
    // expectation and compare the slot that is due now.
    task automatic step(input req_t r, input bit use_exp, input rsp_t e, input string name);
        rsp_t m;
        exp_t x;
        CSN  = r.csn;
        WEN  = r.wen;
        ADDR = r.addr;
        BE   = r.be;
        DI   = r.di;
        @(posedge CLK);
        model_apply(r, m);
        x.name = name;
        x.rsp  = use_exp ? e : m;
        exp_q.push_back(x);
        #1;
        if (exp_q.size() >= READ_LAT) begin
            x = exp_q.pop_front();
            check({x.name, "/dvalid"}, 32'(DVALID), 32'(x.rsp.dv));
            check({x.name, "/err"},    32'(ERR),    32'(x.rsp.err));
            check({x.name, "/dout"},   DOUT,        x.rsp.dout);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "/dvalid"}, 32'(DVALID), 32'h0);
        check({name, "/err"},    32'(ERR),    32'h0);
        check({name, "/dout"},   DOUT,        32'h0);
    endtask

    task automatic prime_queue();
        exp_t x;
        exp_q.delete();
        x.name = "post_reset_idle";
        x.rsp  = '0;
        for (int i = 0; i < READ_LAT - 1; i++) exp_q.push_back(x);
    endtask

    function automatic req_t mk_req(bit csn, bit wen, logic [AW-1:0] addr,
                                    logic [4:0] be, logic [31:0] di);
        req_t r;
        r.csn = csn; r.wen = wen; r.addr = addr; r.be = be; r.di = di;
        return r;
    endfunction

    function automatic vec_t mk(string name, bit csn, bit wen, logic [AW-1:0] addr,
                                logic [4:0] be, logic [31:0] di,
                                bit dv, bit err, logic [31:0] dout);
        vec_t v;
        v.name     = name;
        v.req      = mk_req(csn, wen, addr, be, di);
        v.exp.dv   = dv;
        v.exp.err  = err;
        v.exp.dout = dout;
        return v;
    endfunction

    initial begin
        req_t r;
        rsp_t none;
        none = '0;

        // Directed vectors: {name, csn, wen, addr, be, di, dvalid, err, dout}
        vecs.push_back(mk("wr_w_010",      0, 0, 12'h010, BE_W,  32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk("rd_w_010",      0, 1, 12'h010, BE_W,  32'h0,        1, 0, 32'hDEADBEEF));
        vecs.push_back(mk("wr_w_020",      0, 0, 12'h020, BE_W,  32'h11223344, 0, 0, 32'h0));
        vecs.push_back(mk("wr_b_021",      0, 0, 12'h021, BE_B,  32'h000000AA, 0, 0, 32'h0));
        vecs.push_back(mk("wr_h_022",      0, 0, 12'h022, BE_H,  32'h00005566, 0, 0, 32'h0));
        vecs.push_back(mk("rd_w_020",      0, 1, 12'h020, BE_W,  32'h0,        1, 0, 32'h5566AA44));
        vecs.push_back(mk("rd_bu_023",     0, 1, 12'h023, BE_BU, 32'h0,        1, 0, 32'h00000055));
        vecs.push_back(mk("rd_h_022",      0, 1, 12'h022, BE_H,  32'h0,        1, 0, 32'h00005566));
        vecs.push_back(mk("rd_b_020",      0, 1, 12'h020, BE_B,  32'h0,        1, 0, 32'h00000044));
        vecs.push_back(mk("rd_hu_020",     0, 1, 12'h020, BE_HU, 32'h0,        1, 0, 32'h0000AA44));
        vecs.push_back(mk("wr_w_030",      0, 0, 12'h030, BE_W,  32'hCAFEF00D, 0, 0, 32'h0));
        vecs.push_back(mk("wr_w_031_mis",  0, 0, 12'h031, BE_W,  32'h12345678, 0, 1, 32'h0));
        vecs.push_back(mk("rd_w_030_keep", 0, 1, 12'h030, BE_W,  32'h0,        1, 0, 32'hCAFEF00D));
        vecs.push_back(mk("rd_h_033_mis",  0, 1, 12'h033, BE_H,  32'h0,        0, 1, 32'h0));
        vecs.push_back(mk("rd_be3_040",    0, 1, 12'h040, 5'b00011, 32'h0,     0, 1, 32'h0));
        vecs.push_back(mk("rd_be3_004",    0, 1, 12'h004, 5'b00011, 32'h0,     0, 1, 32'h0));
        vecs.push_back(mk("rd_be0_004",    0, 1, 12'h004, 5'b00000, 32'h0,     0, 1, 32'h0));
        vecs.push_back(mk("wr_h_011_mis",  0, 0, 12'h011, BE_H,  32'h0,        0, 1, 32'h0));
        vecs.push_back(mk("wr_w_000",      0, 0, 12'h000, BE_W,  32'h1,        0, 0, 32'h0));
        vecs.push_back(mk("wr_w_004",      0, 0, 12'h004, BE_W,  32'h2,        0, 0, 32'h0));
        vecs.push_back(mk("wr_w_008",      0, 0, 12'h008, BE_W,  32'h3,        0, 0, 32'h0));
        vecs.push_back(mk("b2b_rd_000",    0, 1, 12'h000, BE_W,  32'h0,        1, 0, 32'h1));
        vecs.push_back(mk("b2b_rd_004",    0, 1, 12'h004, BE_W,  32'h0,        1, 0, 32'h2));
        vecs.push_back(mk("b2b_rd_008",    0, 1, 12'h008, BE_W,  32'h0,        1, 0, 32'h3));
        vecs.push_back(mk("wr_w_03c_top",  0, 0, 12'h03C, BE_W,  32'h0BADCAFE, 0, 0, 32'h0));
        vecs.push_back(mk("rd_w_03c_top",  0, 1, 12'h03C, BE_W,  32'h0,        1, 0, 32'h0BADCAFE));
        vecs.push_back(mk("rd_w_040_oor",  0, 1, 12'h040, BE_W,  32'h0,        0, 1, 32'h0));
        vecs.push_back(mk("wr_w_040_oor",  0, 0, 12'h040, BE_W,  32'h0,        0, 1, 32'h0));
        vecs.push_back(mk("idle_csn1_wr",  1, 0, 12'h010, BE_W,  32'hFFFFFFFF, 0, 0, 32'h0));
        vecs.push_back(mk("rd_w_010_kept", 0, 1, 12'h010, BE_W,  32'h0,        1, 0, 32'hDEADBEEF));
        vecs.push_back(mk("rd_hu_012",     0, 1, 12'h012, BE_HU, 32'h0,        1, 0, 32'h0000DEAD));
        vecs.push_back(mk("rd_b_013",      0, 1, 12'h013, BE_B,  32'h0,        1, 0, 32'h000000DE));
        vecs.push_back(mk("wr_bu_03f",     0, 0, 12'h03F, BE_BU, 32'hFFFFFF77, 0, 0, 32'h0));
        vecs.push_back(mk("rd_w_03c_mrg",  0, 1, 12'h03C, BE_W,  32'h0,        1, 0, 32'h77ADCAFE));
        vecs.push_back(mk("rd_hu_03e",     0, 1, 12'h03E, BE_HU, 32'h0,        1, 0, 32'h000077AD));

        // Reset and reset-state checks.
        RST = 1'b1; CSN = 1'b1; WEN = 1'b1; ADDR = '0; BE = BE_W; DI = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_quiet("reset_state");
        RST = 1'b0;
        prime_queue();

        // Give every word a known value so random reads never see X.
        for (int i = 0; i < DEPTH; i++) begin
            step(mk_req(0, 0, AW'(i * 4), BE_W, 32'hA5000000 | i), 0, none, "prefill");
        end

        // Directed table, applied back to back.
        foreach (vecs[i]) begin
            step(vecs[i].req, 1, vecs[i].exp, vecs[i].name);
        end

        // Reset mid-flight: three reads in flight, the first one on the outputs.
        step(mk_req(0, 1, 12'h010, BE_W, 0), 0, none, "rst_rd_010");
        step(mk_req(0, 1, 12'h014, BE_W, 0), 0, none, "rst_rd_014");
        step(mk_req(0, 1, 12'h018, BE_W, 0), 0, none, "rst_rd_018");
        RST = 1'b1;
        #1;
        check_quiet("rst_async_clear");
        // A write attempted while RST is high must be ignored.
        CSN = 1'b0; WEN = 1'b0; ADDR = 12'h010; BE = BE_W; DI = 32'h0;
        @(posedge CLK);
        #1;
        check_quiet("rst_held");
        RST = 1'b0;
        prime_queue();
        for (int i = 0; i < READ_LAT + 2; i++) begin
            step(mk_req(1, 1, 12'h010, BE_W, 0), 0, none, "rst_no_late_rsp");
        end
        step(mk_req(0, 1, 12'h010, BE_W, 0), 1, '{1'b1, 1'b0, 32'hDEADBEEF}, "rst_reread_010");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            r.csn  = ($urandom_range(0, 3) == 0);
            r.wen  = $urandom_range(0, 1);
            r.addr = AW'($urandom_range(0, DEPTH * 4 + 15));
            if ($urandom_range(0, 7) == 0)
                r.be = 5'($urandom_range(0, 31));
            else
                r.be = 5'b00001 << $urandom_range(0, 4);
            r.di = $urandom;
            step(r, 0, none, "rand");
        end

        // Drain outstanding slots.
        for (int i = 0; i < READ_LAT; i++) begin
            step(mk_req(1, 1, 12'h0, BE_W, 0), 0, none, "drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
